// File: rtl/expand_s_sampler.sv
// Rejection sampler for secret polynomials s1/s2: requests one SHAKE256 stream per
// polynomial and turns squeeze-block nibbles into coefficients in [-ETA, ETA] mod Q.
module expand_s_sampler #(
    parameter int ETA       = 2,
    parameter int K         = 4,
    parameter int L         = 4,
    parameter int RATE_BITS = 1088,
    parameter int Q         = 8380417
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 nonce_valid,
    input  logic                 nonce_ready,
    output logic [15:0]          nonce,
    input  logic                 blk_valid,
    output logic                 blk_ready,
    input  logic [RATE_BITS-1:0] blk_data,
    output logic                 sqz_req,
    output logic                 coef_valid,
    input  logic                 coef_ready,
    output logic [22:0]          coef_data,
    output logic [7:0]           coef_poly,
    output logic [7:0]           coef_idx,
    output logic                 coef_last,
    output logic                 busy,
    output logic                 done
);

    localparam int COEF_W = 23;
    localparam int NIBS   = RATE_BITS / 4;
    localparam int PTR_W  = $clog2(NIBS);
    localparam int NPOLY  = K + L;
    localparam logic [COEF_W-1:0] Q_V       = COEF_W'(Q);
    localparam logic [PTR_W-1:0]  LAST_NIB  = PTR_W'(NIBS - 1);
    localparam logic [15:0]       LAST_POLY = 16'(NPOLY - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_BLK, SAMPLE, DONE} state_t;

    function automatic logic nib_ok(input logic [3:0] b);
        logic ok;
        if (ETA == 2) begin
            ok = (b != 4'hF);
        end else begin
            ok = (b < 4'd9);
        end
        return ok;
    endfunction

    // Negative values wrap to Q+v so every coefficient leaves as a residue in [0,Q).
    function automatic logic [COEF_W-1:0] nib_map(input logic [3:0] b);
        logic [3:0]        r;
        logic [COEF_W-1:0] res;
        r   = b;
        res = '0;
        if (ETA == 2) begin
            if (b >= 4'd10) begin
                r = b - 4'd10;
            end else if (b >= 4'd5) begin
                r = b - 4'd5;
            end else begin
                r = b;
            end
            if (r <= 4'd2) begin
                res = COEF_W'(4'd2 - r);
            end else begin
                res = Q_V - COEF_W'(r - 4'd2);
            end
        end else begin
            if (b <= 4'd4) begin
                res = COEF_W'(4'd4 - b);
            end else begin
                res = Q_V - COEF_W'(b - 4'd4);
            end
        end
        return res;
    endfunction

    state_t               state_r;
    logic [RATE_BITS-1:0] blk_r;
    logic [PTR_W-1:0]     nib_ptr_r;
    logic [8:0]           gen_cnt_r;

    logic [3:0] nib_s;
    logic       hold_s;
    logic       examine_s;
    logic       accept_s;
    logic       coef_hs_s;
    logic       gen_full_s;
    logic       final_acc_s;

    // The block is held in a shift register so the current nibble is always at [3:0].
    assign nib_s       = blk_r[3:0];
    assign hold_s      = coef_valid & ~coef_ready;
    assign coef_hs_s   = coef_valid & coef_ready;
    assign gen_full_s  = (gen_cnt_r == 9'd256);
    assign examine_s   = (state_r == SAMPLE) & ~gen_full_s & ~hold_s;
    assign accept_s    = examine_s & nib_ok(nib_s);
    assign final_acc_s = accept_s & (gen_cnt_r == 9'd255);

    // Control FSM: nonce request, block capture, nibble walk and polynomial sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            blk_r       <= '0;
            nib_ptr_r   <= '0;
            gen_cnt_r   <= 9'd0;
            nonce       <= 16'd0;
            nonce_valid <= 1'b0;
            blk_ready   <= 1'b0;
            sqz_req     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            sqz_req <= 1'b0;
            done    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        nonce       <= 16'd0;
                        gen_cnt_r   <= 9'd0;
                        busy        <= 1'b1;
                        nonce_valid <= 1'b1;
                        state_r     <= REQ;
                    end
                end
                REQ: begin
                    if (nonce_ready) begin
                        nonce_valid <= 1'b0;
                        blk_ready   <= 1'b1;
                        state_r     <= WAIT_BLK;
                    end
                end
                WAIT_BLK: begin
                    if (blk_valid) begin
                        blk_r     <= blk_data;
                        nib_ptr_r <= '0;
                        blk_ready <= 1'b0;
                        state_r   <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (examine_s) begin
                        blk_r     <= blk_r >> 4;
                        nib_ptr_r <= nib_ptr_r + PTR_W'(1);
                        if (accept_s) begin
                            gen_cnt_r <= gen_cnt_r + 9'd1;
                        end
                        // A block ending exactly on the 256th accept needs no further squeeze.
                        if ((nib_ptr_r == LAST_NIB) && !final_acc_s) begin
                            sqz_req   <= 1'b1;
                            blk_ready <= 1'b1;
                            state_r   <= WAIT_BLK;
                        end
                    end else if (gen_full_s && coef_hs_s) begin
                        gen_cnt_r <= 9'd0;
                        nonce     <= nonce + 16'd1;
                        if (nonce == LAST_POLY) begin
                            state_r <= DONE;
                        end else begin
                            nonce_valid <= 1'b1;
                            state_r     <= REQ;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    nonce_valid <= 1'b0;
                    blk_ready   <= 1'b0;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Output coefficient register; a new accept may overwrite in the cycle it is handshaken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coef_valid <= 1'b0;
            coef_data  <= '0;
            coef_poly  <= 8'd0;
            coef_idx   <= 8'd0;
            coef_last  <= 1'b0;
        end else if (accept_s) begin
            coef_valid <= 1'b1;
            coef_data  <= nib_map(nib_s);
            coef_poly  <= nonce[7:0];
            coef_idx   <= gen_cnt_r[7:0];
            coef_last  <= (gen_cnt_r == 9'd255) && (nonce == LAST_POLY);
        end else if (coef_hs_s) begin
            coef_valid <= 1'b0;
            coef_last  <= 1'b0;
        end else begin
            coef_valid <= coef_valid;
        end
    end

endmodule

// File: tb/tb_expand_s_sampler.sv
// Randomized bench for expand_s_sampler: a nibble-level reference model predicts every
// coefficient, nonce and squeeze request; directed tasks cover the corner vectors.
module tb_expand_s_sampler;

    localparam int RB  = 1088;
    localparam int NIB = RB / 4;
    localparam int QM  = 8380417;
    localparam int NP  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, nonce_ready, blk_valid, coef_ready;
    logic [RB-1:0] blk_data;
    logic          nonce_valid, blk_ready, sqz_req, coef_valid, coef_last, busy, done;
    logic [15:0]   nonce;
    logic [22:0]   coef_data;
    logic [7:0]    coef_poly, coef_idx;

    logic          b_start, b_nonce_ready, b_blk_valid, b_coef_ready;
    logic [RB-1:0] b_blk_data;
    logic          b_nonce_valid, b_blk_ready, b_sqz_req, b_coef_valid, b_coef_last, b_busy, b_done;
    logic [15:0]   b_nonce;
    logic [22:0]   b_coef_data;
    logic [7:0]    b_coef_poly, b_coef_idx;

    expand_s_sampler #(.ETA(2), .K(4), .L(4), .RATE_BITS(RB), .Q(QM)) dut (
        .clk(clk), .reset(reset), .start(start),
        .nonce_valid(nonce_valid), .nonce_ready(nonce_ready), .nonce(nonce),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .sqz_req(sqz_req), .coef_valid(coef_valid), .coef_ready(coef_ready),
        .coef_data(coef_data), .coef_poly(coef_poly), .coef_idx(coef_idx),
        .coef_last(coef_last), .busy(busy), .done(done)
    );

    expand_s_sampler #(.ETA(4), .K(1), .L(1), .RATE_BITS(RB), .Q(QM)) dut4 (
        .clk(clk), .reset(reset), .start(b_start),
        .nonce_valid(b_nonce_valid), .nonce_ready(b_nonce_ready), .nonce(b_nonce),
        .blk_valid(b_blk_valid), .blk_ready(b_blk_ready), .blk_data(b_blk_data),
        .sqz_req(b_sqz_req), .coef_valid(b_coef_valid), .coef_ready(b_coef_ready),
        .coef_data(b_coef_data), .coef_poly(b_coef_poly), .coef_idx(b_coef_idx),
        .coef_last(b_coef_last), .busy(b_busy), .done(b_done)
    );

    typedef struct {int val; int poly; int idx; bit last;} coef_t;

    int    errors = 0;
    int    checks = 0;
    coef_t exp_q[$];
    int    got_vals[$];

    // Value of nibble b under the coefficient bound, as a residue mod Q; -1 means rejected.
    function automatic int ref_val(input int b, input int eta);
        int v;
        if (eta == 2) begin
            if (b == 15) return -1;
            v = 2 - (b % 5);
        end else begin
            if (b >= 9) return -1;
            v = 4 - b;
        end
        return (v < 0) ? QM + v : v;
    endfunction

    function automatic logic [RB-1:0] rand_block();
        logic [RB-1:0] r;
        r = '0;
        for (int i = 0; i < RB / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Append this block's surviving coefficients (capped at 256 per polynomial).
    task automatic model_block(input logic [RB-1:0] blk, input int poly, inout int cnt, output bit need_sqz);
        coef_t c;
        int    v;
        for (int i = 0; i < NIB; i++) begin
            v = ref_val(int'(blk[i*4 +: 4]), 2);
            if (v >= 0 && cnt < 256) begin
                c.val = v; c.poly = poly; c.idx = cnt; c.last = (poly == NP - 1) && (cnt == 255);
                exp_q.push_back(c);
                cnt++;
            end
        end
        need_sqz = (cnt < 256);
    endtask

    task automatic idle_inputs();
        start = 1'b0; nonce_ready = 1'b0; blk_valid = 1'b0; coef_ready = 1'b0; blk_data = '0;
        b_start = 1'b0; b_nonce_ready = 1'b0; b_blk_valid = 1'b0; b_coef_ready = 1'b0; b_blk_data = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({nonce_valid, blk_ready, sqz_req, coef_valid, coef_last, busy, done, nonce, coef_data, coef_poly, coef_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b nv=%0b br=%0b cv=%0b nonce=%0d expected all zero", busy, nonce_valid, blk_ready, coef_valid, nonce);
        end
        checks++;
        if ({b_nonce_valid, b_blk_ready, b_coef_valid, b_busy, b_done} !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs_eta4: got %0b expected 0", {b_nonce_valid, b_blk_ready, b_coef_valid, b_busy, b_done});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Full K+L run against the model. mode 0: consumer always ready, 1: random, 2: one 10-cycle stall.
    task automatic run_full(input string name, input int mode, input bit use_forced, input logic [RB-1:0] forced);
        int cyc = 0, next_nonce = 0, cur_poly = 0, cnt = 0, exp_sqz = 0, got_sqz = 0, got_done = 0, ncoef = 0, stall_left = 10;
        bit first_used = 1'b0, need, held = 1'b0;
        logic [22:0] held_data;
        coef_t e;
        exp_q.delete();
        got_vals.delete();
        idle_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || nonce_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_start: got busy=%0b nonce_valid=%0b expected 1 1", name, busy, nonce_valid);
        end
        while (got_done == 0 && cyc < 30000) begin
            if (sqz_req) got_sqz++;
            if (done) begin
                got_done++;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_busy_at_done: got %0b expected 0", name, busy);
                end
            end
            if (held) begin
                checks++;
                if (coef_valid !== 1'b1 || coef_data !== held_data) begin
                    errors++;
                    $display("FAIL %s_stall_stable: got valid=%0b data=%0d expected 1 %0d", name, coef_valid, coef_data, held_data);
                end
                held = 1'b0;
            end
            start = (cyc == 5);
            if (nonce_valid) begin
                nonce_ready = ($urandom_range(0, 2) != 0);
                if (nonce_ready) begin
                    checks++;
                    if (nonce !== 16'(next_nonce)) begin
                        errors++;
                        $display("FAIL %s_nonce: got %0d expected %0d", name, nonce, next_nonce);
                    end
                    cur_poly = next_nonce;
                    next_nonce++;
                    cnt = 0;
                end
            end else begin
                nonce_ready = 1'($urandom_range(0, 1));
            end
            if (blk_ready) begin
                blk_valid = ($urandom_range(0, 3) != 0);
                blk_data  = (use_forced && !first_used) ? forced : rand_block();
                if (blk_valid) begin
                    first_used = 1'b1;
                    model_block(blk_data, cur_poly, cnt, need);
                    if (need) exp_sqz++;
                end
            end else begin
                blk_valid = 1'($urandom_range(0, 1));
                blk_data  = rand_block();
            end
            case (mode)
                0: coef_ready = 1'b1;
                1: coef_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (ncoef >= 100 && stall_left > 0 && coef_valid) begin
                        coef_ready = 1'b0;
                        stall_left--;
                    end else begin
                        coef_ready = 1'b1;
                    end
                end
            endcase
            if (coef_valid && !coef_ready) begin
                held = 1'b1;
                held_data = coef_data;
            end
            if (coef_valid && coef_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra_coef: got data=%0d poly=%0d idx=%0d expected none", name, coef_data, coef_poly, coef_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (coef_data !== 23'(e.val) || coef_poly !== 8'(e.poly) || coef_idx !== 8'(e.idx) || coef_last !== e.last) begin
                        errors++;
                        $display("FAIL %s_coef: got %0d/p%0d/i%0d/l%0b expected %0d/p%0d/i%0d/l%0b",
                                 name, coef_data, coef_poly, coef_idx, coef_last, e.val, e.poly, e.idx, e.last);
                    end
                end
                got_vals.push_back(int'(coef_data));
                ncoef++;
            end
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        checks++;
        if (got_done != 1) begin
            errors++;
            $display("FAIL %s_timeout: got done=%0d after %0d cycles expected 1", name, got_done, cyc);
        end
        repeat (5) begin
            if (done) got_done++;
            @(negedge clk);
        end
        checks++;
        if (got_done != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_single_done: got done=%0d busy=%0b expected 1 0", name, got_done, busy);
        end
        checks++;
        if (ncoef != NP * 256 || exp_q.size() != 0 || next_nonce != NP) begin
            errors++;
            $display("FAIL %s_totals: got coefs=%0d left=%0d nonces=%0d expected %0d 0 %0d", name, ncoef, exp_q.size(), next_nonce, NP * 256, NP);
        end
        checks++;
        if (got_sqz != exp_sqz) begin
            errors++;
            $display("FAIL %s_sqz_count: got %0d expected %0d", name, got_sqz, exp_sqz);
        end
    endtask

    task automatic test_eta2_vector();
        logic [RB-1:0] f;
        f = rand_block();
        f[7:0]  = 8'h10;
        f[15:8] = 8'hF4;
        run_full("eta2_vec", 0, 1'b1, f);
        checks++;
        if (got_vals.size() < 3 || got_vals[0] != 2 || got_vals[1] != 1 || got_vals[2] != 8380415) begin
            errors++;
            $display("FAIL eta2_vector: got %0d %0d %0d expected 2 1 8380415",
                     got_vals.size() > 0 ? got_vals[0] : -1, got_vals.size() > 1 ? got_vals[1] : -1, got_vals.size() > 2 ? got_vals[2] : -1);
        end
    endtask

    task automatic test_all_ff();
        int k = 0;
        bit saw_coef = 1'b0;
        idle_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nonce_ready = 1'b1;
        while (!blk_ready && k < 20) begin @(negedge clk); k++; end
        nonce_ready = 1'b0;
        blk_valid = 1'b1;
        blk_data  = '1;
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data  = '0;
        coef_ready = 1'b1;
        k = 0;
        while (!sqz_req && k < 1000) begin
            if (coef_valid) saw_coef = 1'b1;
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != NIB || saw_coef) begin
            errors++;
            $display("FAIL all_ff_sqz: got %0d cycles coef_seen=%0b expected %0d 0", k, saw_coef, NIB);
        end
        checks++;
        if (blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL all_ff_wait_blk: got blk_ready=%0b expected 1", blk_ready);
        end
        @(negedge clk);
        checks++;
        if (sqz_req !== 1'b0) begin
            errors++;
            $display("FAIL all_ff_sqz_pulse: got %0b expected 0", sqz_req);
        end
        apply_reset();
    endtask

    task automatic test_eta4();
        logic [RB-1:0] blk;
        int expv[$];
        int got[$];
        int k = 0, v;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_nonce_ready = 1'b1;
        while (!b_blk_ready && k < 20) begin @(negedge clk); k++; end
        b_nonce_ready = 1'b0;
        blk = rand_block();
        blk[7:0] = 8'h98;
        b_blk_data  = blk;
        b_blk_valid = 1'b1;
        b_coef_ready = 1'b1;
        for (int i = 0; i < NIB && expv.size() < 4; i++) begin
            v = ref_val(int'(blk[i*4 +: 4]), 4);
            if (v >= 0) expv.push_back(v);
        end
        @(negedge clk);
        b_blk_valid = 1'b0;
        k = 0;
        while (got.size() < 4 && k < 200) begin
            if (b_coef_valid) got.push_back(int'(b_coef_data));
            @(negedge clk);
            k++;
        end
        checks++;
        if (got.size() < 4 || got[0] != 8380413) begin
            errors++;
            $display("FAIL eta4_first: got %0d coefs first=%0d expected 4 8380413", got.size(), got.size() > 0 ? got[0] : -1);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] != expv[i]) begin
                    errors++;
                    $display("FAIL eta4_seq: got %0d expected %0d at %0d", got[i], expv[i], i);
                end
            end
        end
        apply_reset();
    endtask

    task automatic test_reset_mid();
        int k = 0, after = -1;
        bit on3 = 1'b0;
        idle_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (k < 20000 && (after < 0 || after < 20)) begin
            if (nonce_valid && nonce == 16'd3) on3 = 1'b1;
            nonce_ready = 1'b1;
            coef_ready  = 1'b1;
            blk_valid   = blk_ready;
            blk_data    = rand_block();
            if (after >= 0) after++;
            if (on3 && blk_ready && after < 0) after = 0;
            @(negedge clk);
            k++;
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (!on3 || {nonce_valid, blk_ready, sqz_req, coef_valid, coef_last, busy, done, nonce, coef_data, coef_poly, coef_idx} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got reached3=%0b busy=%0b cv=%0b nonce=%0d expected 1 0 0 0", on3, busy, coef_valid, nonce);
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (nonce_valid !== 1'b1 || nonce !== 16'd0) begin
            errors++;
            $display("FAIL restart_nonce: got valid=%0b nonce=%0d expected 1 0", nonce_valid, nonce);
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_eta2_vector();
        run_full("random_ready", 1, 1'b0, '0);
        run_full("stall10", 2, 1'b0, '0);
        test_all_ff();
        test_eta4();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
